// File: rtl/arm_mem_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
//   state_t       : access sequencer states
//   SRAM_DW       : external SRAM data width
//   DEF_BASE_ADDR : default byte address mapped to SRAM half-word 0
//   CNT_W         : wait counter width (covers WAIT_CYCLES 0..7)
package arm_mem_pkg;

  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int unsigned CNT_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter for the SRAM controller.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (priority over en)
//   en       : count up by one
//   last     : high when the phase has been held WAIT_CYCLES+1 cycles
module sram_wait_counter
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit
// SRAM accesses (low half first) and freezes the pipeline via ready.
//   clk, rst    : clock, async active-high reset
//   MEM_R_EN    : load request
//   MEM_W_EN    : store request (wins when both are set)
//   address     : byte address
//   write_data  : store data
//   read_data   : assembled load data, held until the next load
//   ready       : combinational; 0 freezes the pipeline
//   SRAM_DQ     : bidirectional SRAM data bus
//   SRAM_ADDR   : SRAM half-word address
//   SRAM_WE_N   : SRAM write strobe, active low
module mem_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_R_EN,
  input  logic                  MEM_W_EN,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  ready,
  inout  wire  [SRAM_DW-1:0]    SRAM_DQ,
  output logic [SRAM_AW-1:0]    SRAM_ADDR,
  output logic                  SRAM_WE_N
);

  localparam int unsigned WA_W = SRAM_AW - 1;

  state_t              state;
  state_t              state_d;
  logic                req;
  logic                cnt_clr;
  logic                cnt_en;
  logic                last;

  logic                write_q;
  logic [WA_W-1:0]     word_q;
  logic [31:0]         wdata_q;
  logic                op_d;
  logic [WA_W-1:0]     word_d;
  logic [31:0]         wdata_d;

  logic [31:0]         offset;
  logic [WA_W-1:0]     word_in;
  logic                unused_addr_bits;

  logic [SRAM_DW-1:0]  dq_out;
  logic                dq_oe;

  assign req = MEM_R_EN | MEM_W_EN;

  // Byte offset from base, word index wraps modulo the SRAM word count.
  assign offset           = address - 32'(BASE_ADDR);
  assign word_in          = offset[WA_W+1:2];
  assign unused_addr_bits = ^{offset[31:WA_W+2], offset[1:0]};

  assign ready   = ((state == IDLE) && !req) || (state == DONE);
  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

  // Phase timing
  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (last)
  );

  // Request latch, taken when an access is accepted in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else if ((state == IDLE) && req) begin
      write_q <= MEM_W_EN;
      word_q  <= word_in;
      wdata_q <= write_data;
    end
  end

  // Request fields as seen by the next cycle (bypass the latch on accept)
  always_comb begin
    op_d    = write_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    if (state == IDLE) begin
      op_d    = MEM_W_EN;
      word_d  = word_in;
      wdata_d = write_data;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_d = state;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_clr = 1'b1;
        end
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so strobes never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SRAM_WE_N <= 1'b1;
      SRAM_ADDR <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      case (state_d)
        LO: begin
          SRAM_ADDR <= {word_d, 1'b0};
          SRAM_WE_N <= ~op_d;
          dq_oe     <= op_d;
          dq_out    <= wdata_d[SRAM_DW-1:0];
        end
        HI: begin
          SRAM_ADDR <= {word_d, 1'b1};
          SRAM_WE_N <= ~op_d;
          dq_oe     <= op_d;
          dq_out    <= wdata_d[2*SRAM_DW-1:SRAM_DW];
        end
        default: ;
      endcase
    end
  end

  // Load capture on the final cycle of each read phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (!write_q && last) begin
      if (state == LO) begin
        read_data[SRAM_DW-1:0] <= SRAM_DQ;
      end else if (state == HI) begin
        read_data[2*SRAM_DW-1:SRAM_DW] <= SRAM_DQ;
      end
    end
  end

endmodule
